// File: rtl/lane_skid_stage_pkg.sv
// Shared constants and lane-slicing helper for the core pipeline stage registers.
package lane_skid_stage_pkg;

    localparam int unsigned LANES_DEF  = 2;
    localparam int unsigned DATA_W_DEF = 32;

    // Base bit of lane k inside a packed group of w-bit lanes.
    function automatic int unsigned lane_base(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/lane_prefix_accept.sv
// In-order effective-accept mask: a lane leaves only if every earlier valid lane also leaves.
module lane_prefix_accept
    import lane_skid_stage_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic [LANES-1:0] valid_i,
    input  logic [LANES-1:0] accept_i,
    output logic [LANES-1:0] eff_o
);

    logic blocked;

    always_comb begin
        blocked = 1'b0;
        eff_o   = '0;
        for (int k = 0; k < LANES; k++) begin
            eff_o[k] = accept_i[k] & valid_i[k] & ~blocked;
            // A valid lane that stays put blocks every later lane.
            blocked  = blocked | (valid_i[k] & ~eff_o[k]);
        end
    end

endmodule

// File: rtl/lane_skid_stage.sv
// N-lane pipeline stage with one-group skid buffer, per-lane in-order drain,
// synchronous flush and a saturating stall-cycle counter.
module lane_skid_stage
    import lane_skid_stage_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        in_valid_i,
    input  logic [LANES*DATA_W-1:0] in_data_i,
    output logic                    in_ready_o,
    output logic [LANES-1:0]        out_valid_o,
    output logic [LANES*DATA_W-1:0] out_data_o,
    input  logic [LANES-1:0]        out_accept_i,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    logic [LANES-1:0]        head_valid_q, head_valid_d;
    logic [LANES*DATA_W-1:0] head_data_q, head_data_d;
    logic [LANES-1:0]        skid_valid_q, skid_valid_d;
    logic [LANES*DATA_W-1:0] skid_data_q, skid_data_d;
    logic                    skid_full_q, skid_full_d;
    logic                    ready_q, ready_d;
    logic [CNT_W-1:0]        stall_q, stall_d;

    logic [LANES-1:0] eff;
    logic [LANES-1:0] head_keep;
    logic             push;
    logic             drain;

    lane_prefix_accept #(
        .LANES (LANES)
    ) u_prefix_accept (
        .valid_i  (head_valid_q),
        .accept_i (out_accept_i),
        .eff_o    (eff)
    );

    always_comb begin
        push      = ready_q & (|in_valid_i);
        head_keep = head_valid_q & ~eff;
        drain     = ~|head_keep;

        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_full_d  = skid_full_q;
        stall_d      = stall_q;

        if (flush_i) begin
            head_valid_d = '0;
            skid_full_d  = 1'b0;
        end else begin
            if (drain && skid_full_q) begin
                head_valid_d = skid_valid_q;
                head_data_d  = skid_data_q;
                skid_full_d  = 1'b0;
            end else if (drain && push) begin
                head_valid_d = in_valid_i;
                head_data_d  = in_data_i;
            end else begin
                head_valid_d = head_keep;
            end
            // Anything pushed that did not land in the head goes to the skid.
            if (push && !(drain && !skid_full_q)) begin
                skid_valid_d = in_valid_i;
                skid_data_d  = in_data_i;
                skid_full_d  = 1'b1;
            end
            if ((|head_valid_q) && !(|eff) && !(&stall_q)) begin
                stall_d = stall_q + 1'b1;
            end
        end

        ready_d = ~skid_full_d;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            head_valid_q <= '0;
            head_data_q  <= '0;
            skid_valid_q <= '0;
            skid_data_q  <= '0;
            skid_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            stall_q      <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_full_q  <= skid_full_d;
            ready_q      <= ready_d;
            stall_q      <= stall_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = head_valid_q;
    assign out_data_o  = head_data_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_lane_skid_stage.sv
// Scoreboard bench: a group-queue model predicts occupancy, and delivered lanes are
// checked in order against the payloads recorded at push time.
module tb_lane_skid_stage;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CAP    = 2;

    logic                    clock_i = 1'b0;
    logic                    resetn_i = 1'b0;
    logic                    flush_i = 1'b0;
    logic [LANES-1:0]        in_valid_i = '0;
    logic [LANES*DATA_W-1:0] in_data_i = '0;
    logic                    in_ready_o;
    logic [LANES-1:0]        out_valid_o;
    logic [LANES*DATA_W-1:0] out_data_o;
    logic [LANES-1:0]        out_accept_i = '0;
    logic [CNT_W-1:0]        stall_cnt_o;

    lane_skid_stage #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock_i      (clock_i),
        .resetn_i     (resetn_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_accept_i (out_accept_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    // Model state: held groups (valid masks, oldest first) and outstanding lane payloads.
    logic [LANES-1:0]  grp_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              ready_m = 1'b1;
    int                stall_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LANES-1:0] in_order_accept(input logic [LANES-1:0] v,
                                                          input logic [LANES-1:0] a);
        logic [LANES-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (v[k]) begin
                if (!a[k]) break;
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference model, advanced on every active edge.
    always @(posedge clock_i or negedge resetn_i) begin
        logic [LANES-1:0] hv, e;
        if (!resetn_i) begin
            grp_q.delete();
            exp_q.delete();
            ready_m = 1'b1;
            stall_m = 0;
        end else if (flush_i) begin
            grp_q.delete();
            exp_q.delete();
            ready_m = 1'b1;
        end else begin
            hv = (grp_q.size() > 0) ? grp_q[0] : '0;
            e  = in_order_accept(hv, out_accept_i);
            if (hv != 0 && e == 0 && stall_m < (1 << CNT_W) - 1) stall_m++;
            if (hv != 0) begin
                grp_q[0] = hv & ~e;
                if (grp_q[0] == 0) void'(grp_q.pop_front());
            end
            if (ready_m && in_valid_i != 0) begin
                grp_q.push_back(in_valid_i);
                for (int k = 0; k < LANES; k++)
                    if (in_valid_i[k]) exp_q.push_back(in_data_i[k*DATA_W +: DATA_W]);
            end
            ready_m = grp_q.size() < CAP;
        end
    end

    // Monitor: compares state and pops a payload for every lane the DUT hands over.
    always @(negedge clock_i) begin
        logic [LANES-1:0] e;
        logic [DATA_W-1:0] want;
        if (resetn_i) begin
            check("in_ready", 64'(in_ready_o), 64'(ready_m));
            check("out_valid", 64'(out_valid_o), 64'((grp_q.size() > 0) ? grp_q[0] : '0));
            check("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
            if (!flush_i) begin
                e = in_order_accept(out_valid_o, out_accept_i);
                for (int k = 0; k < LANES; k++) begin
                    if (e[k]) begin
                        if (exp_q.size() == 0) begin
                            check("lane_data_unexpected", 64'(out_data_o[k*DATA_W +: DATA_W]),
                                  64'hdead_0000);
                        end else begin
                            want = exp_q.pop_front();
                            check("lane_data", 64'(out_data_o[k*DATA_W +: DATA_W]), 64'(want));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic [LANES-1:0] v, input logic [63:0] d,
                         input logic [LANES-1:0] a, input logic f);
        in_valid_i   = v;
        in_data_i    = d;
        out_accept_i = a;
        flush_i      = f;
    endtask

    initial begin
        #12;
        check("reset_out_valid", 64'(out_valid_o), 64'h0);
        check("reset_in_ready", 64'(in_ready_o), 64'h1);
        check("reset_stall", 64'(stall_cnt_o), 64'h0);
        @(posedge clock_i);
        #1 resetn_i = 1'b1;

        // First group appears one cycle after the push.
        drive(2'b11, {32'h22, 32'h11}, 2'b00, 1'b0);
        step();
        drive(2'b00, 64'h0, 2'b00, 1'b0);
        check("first_valid", 64'(out_valid_o), 64'h3);
        check("first_data", out_data_o, {32'h22, 32'h11});
        check("first_ready", 64'(in_ready_o), 64'h1);

        // Lane 0 leaves, then lane 1.
        drive(2'b00, 64'h0, 2'b01, 1'b0);
        step();
        check("partial_valid", 64'(out_valid_o), 64'h2);
        check("partial_data1", 64'(out_data_o[63:32]), 64'h22);
        drive(2'b00, 64'h0, 2'b10, 1'b0);
        step();
        check("drained_valid", 64'(out_valid_o), 64'h0);

        // Out-of-order accept is ignored and counts a stall.
        drive(2'b11, {32'h44, 32'h33}, 2'b00, 1'b0);
        step();
        drive(2'b00, 64'h0, 2'b10, 1'b0);
        step();
        check("ooo_valid", 64'(out_valid_o), 64'h3);
        check("ooo_stall", 64'(stall_cnt_o), 64'h1);
        drive(2'b00, 64'h0, 2'b11, 1'b0);
        step();

        // B into head, C into skid, then drain B.
        drive(2'b11, {32'hb1, 32'hb0}, 2'b00, 1'b0);
        step();
        drive(2'b11, {32'hc1, 32'hc0}, 2'b00, 1'b0);
        step();
        check("skid_full_ready", 64'(in_ready_o), 64'h0);
        check("skid_head_data", out_data_o, {32'hb1, 32'hb0});
        drive(2'b00, 64'h0, 2'b11, 1'b0);
        step();
        drive(2'b00, 64'h0, 2'b00, 1'b0);
        check("c_head_data", out_data_o, {32'hc1, 32'hc0});
        check("c_ready", 64'(in_ready_o), 64'h1);
        drive(2'b00, 64'h0, 2'b11, 1'b0);
        step();

        // Flush together with a genuine push discards everything.
        drive(2'b11, {32'he1, 32'he0}, 2'b00, 1'b0);
        step();
        drive(2'b11, {32'hf1, 32'hf0}, 2'b11, 1'b1);
        step();
        drive(2'b00, 64'h0, 2'b00, 1'b0);
        check("flush_valid", 64'(out_valid_o), 64'h0);
        check("flush_ready", 64'(in_ready_o), 64'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(2'($urandom), {$urandom, $urandom}, 2'($urandom),
                  ($urandom_range(0, 24) == 0));
            step();
        end

        // Stall saturation.
        drive(2'b00, 64'h0, 2'b00, 1'b1);
        step();
        drive(2'b01, {32'h0, 32'h77}, 2'b00, 1'b0);
        step();
        drive(2'b00, 64'h0, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check("stall_saturated", 64'(stall_cnt_o), 64'hf);

        // Asynchronous reset mid-cycle.
        @(posedge clock_i);
        #2 resetn_i = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid_o), 64'h0);
        check("async_ready", 64'(in_ready_o), 64'h1);
        check("async_stall", 64'(stall_cnt_o), 64'h0);
        @(posedge clock_i);
        #1 resetn_i = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
